// File: rtl/rram_write_verify_ctrl.sv
// Write/verify sequencer for the 64x64 single-port RRAM macro.
// Define RRAM_WRITE_VERIFY_EN to enable read-back verify and retries.
module rram_write_verify_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RETRY_W    = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fail,
  output logic [RETRY_W-1:0]    resp_retries,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  // The retry counter must be able to hold MAX_RETRY.
  if (MAX_RETRY >= (1 << RETRY_W)) begin : g_bad_max_retry
    $error("MAX_RETRY must be below 2**RETRY_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
`ifdef RRAM_WRITE_VERIFY_EN
    VRD,
    VCAP,
`endif
    RD,
    RCAP,
    DONE
  } state_e;

`ifdef RRAM_WRITE_VERIFY_EN
  localparam logic [RETRY_W-1:0] MAX_R =
    RETRY_W'(MAX_RETRY);
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  fail_q, fail_d;

  // State, request latches and response registers.
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
    end
  end

  // Next state and macro strobes, decoded from registered state only.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    retry_d    = retry_q;
    fail_d     = fail_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_csb0   = 1'b1;
    mem_web0   = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          retry_d = '0;
          fail_d  = 1'b0;
          state_d = req_we ? WR : RD;
        end
      end
      WR: begin
        mem_csb0 = 1'b0;
        mem_web0 = 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
        state_d  = VRD;
`else
        state_d  = DONE;
`endif
      end
`ifdef RRAM_WRITE_VERIFY_EN
      VRD: begin
        mem_csb0 = 1'b0;
        state_d  = VCAP;
      end
      VCAP: begin
        rdata_d = mem_dout0;
        if (mem_dout0 == wdata_q) begin
          state_d = DONE;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = WR;
        end else begin
          fail_d  = 1'b1;
          state_d = DONE;
        end
      end
`endif
      RD: begin
        mem_csb0 = 1'b0;
        state_d  = RCAP;
      end
      RCAP: begin
        rdata_d = mem_dout0;
        state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr0    = addr_q;
  assign mem_din0     = wdata_q;
  assign resp_rdata   = rdata_q;
  assign resp_fail    = fail_q;
  assign resp_retries = retry_q;

endmodule
